// File: rtl/echo_delay_stage.sv
// echo_delay_stage: single-channel Avalon-ST echo/delay effect.
// Output = input + (input delayed DEPTH samples >>> ATTEN_SHIFT), saturated,
// when the latched enable is set; bit-exact passthrough otherwise.
// Optional build macro ECHO_FEEDBACK_EN: the delay buffer stores the mixed
// output instead of the raw input, producing decaying repeated echoes.
module echo_delay_stage #(
    parameter int DATA_W      = 24,
    parameter int DEPTH       = 4096,
    parameter int ATTEN_SHIFT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     switch_delay,
    input  logic signed [DATA_W-1:0] sink_data,
    input  logic                     sink_valid,
    output logic                     sink_ready,
    output logic signed [DATA_W-1:0] source_data,
    output logic                     source_valid,
    input  logic                     source_ready,
    output logic                     active
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, CALC, OUT} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic signed [DATA_W-1:0]   mem [DEPTH];
    logic signed [DATA_W-1:0]   in_p0;
    logic signed [DATA_W-1:0]   ram_q_p1;
    logic signed [DATA_W-1:0]   dly;
    logic signed [DATA_W-1:0]   dly_sh;
    logic signed [DATA_W:0]     sum;
    logic signed [DATA_W-1:0]   result;
    logic signed [DATA_W-1:0]   wr_data;
    logic [AW-1:0]              wr_ptr;
    logic [FW-1:0]              fill;
    logic                       en;
    logic                       sink_hs;
    logic                       source_hs;

    // Clamp a DATA_W+1 bit sum into the DATA_W two's-complement range.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1])
            sat = v[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        else
            sat = v[DATA_W-1:0];
    endfunction

    // Handshakes are suppressed during reset so a held sample is simply dropped.
    assign sink_ready   = (state == IDLE) && !reset;
    assign source_valid = (state == OUT) && !reset;
    assign sink_hs      = sink_ready && sink_valid;
    assign source_hs    = source_valid && source_ready;

    // Mix path: history only counts once the buffer holds DEPTH samples since enable.
    always_comb begin
        dly    = (fill == FILL_FULL) ? ram_q_p1 : '0;
        dly_sh = dly >>> ATTEN_SHIFT;
        sum    = {in_p0[DATA_W-1], in_p0} + {dly_sh[DATA_W-1], dly_sh};
        result = en ? sat(sum) : in_p0;
`ifdef ECHO_FEEDBACK_EN
        wr_data = result;
`else
        wr_data = in_p0;
`endif
    end

    // Next-state logic for the four-phase sample sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sink_hs) state_nxt = RD;
            RD:      state_nxt = CALC;
            CALC:    state_nxt = OUT;
            OUT:     if (source_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: capture the accepted input sample.
    always_ff @(posedge clk) begin
        if (sink_hs)
            in_p0 <= sink_data;
    end

    // Stage p1: registered buffer read at the write pointer (oldest entry).
    always_ff @(posedge clk) begin
        ram_q_p1 <= mem[wr_ptr];
    end

    // Delay buffer write, one entry per processed sample.
    always_ff @(posedge clk) begin
        if (state == CALC)
            mem[wr_ptr] <= wr_data;
    end

    // Control state: FSM, pointers, fill level, enable latch and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            fill        <= '0;
            en          <= 1'b0;
            active      <= 1'b0;
            source_data <= '0;
        end else begin
            state <= state_nxt;
            if (sink_hs) begin
                en <= switch_delay;
                if (!en && switch_delay)
                    fill <= '0;
            end
            if (state == CALC) begin
                source_data <= result;
                active      <= en && (fill == FILL_FULL);
                wr_ptr      <= wr_ptr + 1'b1;
                if (fill != FILL_FULL)
                    fill <= fill + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_echo_delay_stage.sv
// Testbench for echo_delay_stage (DEPTH=8): scoreboard driven by a
// behavioural echo model; bypass, echo, saturation, backpressure and reset.
module tb_echo_delay_stage;

    localparam int DATA_W = 24;
    localparam int DEPTH  = 8;
    localparam int SH     = 1;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     switch_delay;
    logic signed [DATA_W-1:0] sink_data;
    logic                     sink_valid;
    logic                     sink_ready;
    logic signed [DATA_W-1:0] source_data;
    logic                     source_valid;
    logic                     source_ready;
    logic                     active;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc = 0;
    bit lat_chk = 1'b0;
    bit prev_sv = 1'b0;

    logic signed [DATA_W-1:0] expq [$];

    // behavioural model state
    logic signed [DATA_W-1:0] m_hist [DEPTH];
    int m_wp   = 0;
    int m_fill = 0;
    bit m_en   = 1'b0;

    echo_delay_stage #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ATTEN_SHIFT(SH)) dut (
        .clk(clk), .reset(reset), .switch_delay(switch_delay),
        .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
        .source_data(source_data), .source_valid(source_valid),
        .source_ready(source_ready), .active(active)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic signed [DATA_W-1:0] model_step(input logic signed [DATA_W-1:0] x,
                                                          input bit sw);
        logic signed [DATA_W-1:0] d;
        logic signed [DATA_W+1:0] s;
        logic signed [DATA_W-1:0] r;
        if (!m_en && sw) m_fill = 0;
        m_en = sw;
        d = (m_fill == DEPTH) ? m_hist[m_wp] : '0;
        s = DATA_W'(x) + (d >>> SH);
        s = $signed(x) + $signed(d >>> SH);
        if (s > 32'sh7FFFFF)       r = 24'h7FFFFF;
        else if (s < -32'sh800000) r = 24'h800000;
        else                        r = s[DATA_W-1:0];
        if (!m_en) r = x;
`ifdef ECHO_FEEDBACK_EN
        m_hist[m_wp] = r;
`else
        m_hist[m_wp] = x;
`endif
        m_wp = (m_wp + 1) % DEPTH;
        if (m_fill < DEPTH) m_fill++;
        return r;
    endfunction

    // output monitor: pops the scoreboard on each source handshake
    always @(negedge clk) begin
        if (!reset && source_valid && source_ready) begin
            if (expq.size() == 0) check("unexpected_out", source_data, 32'hDEAD);
            else check("out_data", 32'(source_data), 32'(expq.pop_front()));
        end
        if (lat_chk && source_valid && !prev_sv)
            check("latency", cyc - acc_cyc, 3);
        prev_sv <= source_valid;
    end

    task automatic send(input logic signed [DATA_W-1:0] x, input bit sw);
        bit done = 1'b0;
        sink_data = x; switch_delay = sw; sink_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (sink_ready) begin
                acc_cyc = cyc;
                expq.push_back(model_step(x, sw));
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        sink_valid = 1'b0;
        if (!done) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (expq.size() != 0) check("drain_timeout", expq.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("rst_source_valid", source_valid, 0);
            check("rst_sink_ready", sink_ready, 0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
        expq.delete();
        m_wp = 0; m_fill = 0; m_en = 1'b0;
        @(negedge clk);
        check("post_rst_sink_ready", sink_ready, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic signed [DATA_W-1:0] held;
        int n;
        reset = 1'b1; switch_delay = 1'b0; sink_data = '0; sink_valid = 1'b0;
        source_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_sink_ready0", sink_ready, 0);
        check("rst_source_valid0", source_valid, 0);
        check("rst_source_data0", source_data, 0);
        check("rst_active0", active, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // bypass with latency check
        lat_chk = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            send(DATA_W'(i), 1'b0);
            drain();
        end
        lat_chk = 1'b0;
        check("bypass_active", active, 0);

        // echo: impulse then zeros
        send(24'sd1000, 1'b1); drain();
        for (int i = 0; i < 26; i++) begin send(24'sd0, 1'b1); drain(); end
        check("echo_active", active, 1);

        // positive saturation: fresh enable, prime with full-scale positive
        send(24'sd5, 1'b0); drain();
        for (int i = 0; i < DEPTH + 2; i++) begin send(24'sh7FFFFF, 1'b1); drain(); end
        // negative saturation
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin send(24'sh800000, 1'b1); drain(); end

        // backpressure: output held for 20 cycles
        source_ready = 1'b0;
        send(24'sh123456, 1'b1);
        n = 0;
        while (!source_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("bp_valid", source_valid, 1);
        held = source_data;
        sink_valid = 1'b1; sink_data = 24'sh0BAD00;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("bp_data_stable", source_data, held);
            check("bp_sink_ready", sink_ready, 0);
        end
        sink_valid = 1'b0;
        @(posedge clk); #1;
        source_ready = 1'b1;
        drain();
        check("bp_no_dup", expq.size(), 0);
        send(24'sh000042, 1'b1); drain();

        // reset mid-OUT
        source_ready = 1'b0;
        send(24'sh000777, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        do_reset(3);
        source_ready = 1'b1;
        send(24'sh000011, 1'b0); drain();
        send(24'sh000022, 1'b0); drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
